// File: rtl/silife_max7219_stream.sv
// SPI streamer for a chain of CHAIN MAX7219 drivers: init sequence when needed, then 8 row transactions per frame.
// Optional SILIFE_STREAM_MIRROR_EN adds cfg_mirror, which bit-reverses each row across the whole chain.
module silife_max7219_stream #(
  parameter int CHAIN = 4,
  parameter int DIV_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [3:0]         cfg_intensity,
`ifdef SILIFE_STREAM_MIRROR_EN
  input  logic               cfg_mirror,
`endif
  output logic [2:0]         row_sel,
  input  logic [8*CHAIN-1:0] row_data,
  output logic               spi_cs,
  output logic               spi_sck,
  output logic               spi_mosi,
  output logic               busy,
  output logic               frame_done
);

  localparam int W     = 8 * CHAIN;
  localparam int NBITS = 16 * CHAIN;
  localparam int BCW   = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_LOAD, S_INIT_SHIFT, S_ROW_LOAD, S_ROW_SHIFT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         intensity_q, intensity_d;
  logic [3:0]         init_int_q, init_int_d;
  logic               init_pending_q, init_pending_d;
  logic [2:0]         init_idx_q, init_idx_d;
  logic [2:0]         row_q, row_d;
  logic               load_ph_q, load_ph_d;
  logic [DIV_W:0]     tick_q, tick_d;
  logic               sck_q, sck_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;
  logic               gap_q, gap_d;
  logic [BCW-1:0]     bit_q, bit_d;
  logic [NBITS-1:0]   shift_q, shift_d;
`ifdef SILIFE_STREAM_MIRROR_EN
  logic               mirror_q, mirror_d;
`endif

  logic [W-1:0]       row_word;
  logic [NBITS-1:0]   load_word;
  logic               load_go;
  logic               xfer_end;

  function automatic logic [15:0] init_cmd(input logic [2:0] idx, input logic [3:0] inten);
    case (idx)
      3'd0:    init_cmd = 16'h0C01;
      3'd1:    init_cmd = 16'h0900;
      3'd2:    init_cmd = 16'h0B07;
      3'd3:    init_cmd = {12'h0A0, inten};
      default: init_cmd = 16'h0F00;
    endcase
  endfunction

  // Device 0 occupies the low 16 bits so it is shifted out last and ends up nearest MOSI.
  function automatic logic [NBITS-1:0] row_frame(input logic [2:0] r, input logic [W-1:0] data);
    logic [3:0] addr;
    addr      = {1'b0, r} + 4'd1;
    row_frame = '0;
    for (int dev = 0; dev < CHAIN; dev++)
      row_frame[16*dev +: 16] = {4'h0, addr, data[8*dev +: 8]};
  endfunction

`ifdef SILIFE_STREAM_MIRROR_EN
  function automatic logic [W-1:0] reverse_row(input logic [W-1:0] v);
    reverse_row = '0;
    for (int i = 0; i < W; i++) reverse_row[i] = v[W-1-i];
  endfunction
`endif

  // NOTE: every state bit is registered with <= so all of them see pre-edge values;
  // reset is asynchronous so the pads go quiet without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      div_q          <= '0;
      intensity_q    <= '0;
      init_int_q     <= '0;
      init_pending_q <= 1'b1;
      init_idx_q     <= '0;
      row_q          <= '0;
      load_ph_q      <= 1'b0;
      tick_q         <= '0;
      sck_q          <= 1'b0;
      cs_q           <= 1'b1;
      mosi_q         <= 1'b0;
      gap_q          <= 1'b0;
      bit_q          <= '0;
      shift_q        <= '0;
`ifdef SILIFE_STREAM_MIRROR_EN
      mirror_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      intensity_q    <= intensity_d;
      init_int_q     <= init_int_d;
      init_pending_q <= init_pending_d;
      init_idx_q     <= init_idx_d;
      row_q          <= row_d;
      load_ph_q      <= load_ph_d;
      tick_q         <= tick_d;
      sck_q          <= sck_d;
      cs_q           <= cs_d;
      mosi_q         <= mosi_d;
      gap_q          <= gap_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
`ifdef SILIFE_STREAM_MIRROR_EN
      mirror_q       <= mirror_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every _d and helper gets its hold value first, so no branch can infer a latch.
    state_d        = state_q;
    div_d          = div_q;
    intensity_d    = intensity_q;
    init_int_d     = init_int_q;
    init_pending_d = init_pending_q;
    init_idx_d     = init_idx_q;
    row_d          = row_q;
    load_ph_d      = load_ph_q;
    tick_d         = tick_q;
    sck_d          = sck_q;
    cs_d           = cs_q;
    mosi_d         = mosi_q;
    gap_d          = gap_q;
    bit_d          = bit_q;
    shift_d        = shift_q;
    load_go        = 1'b0;
    load_word      = '0;
    xfer_end       = 1'b0;
    row_word       = row_data;
`ifdef SILIFE_STREAM_MIRROR_EN
    mirror_d       = mirror_q;
    if (mirror_q) row_word = reverse_row(row_data);
`endif

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          div_d       = cfg_div;
          intensity_d = cfg_intensity;
          row_d       = '0;
          load_ph_d   = 1'b0;
`ifdef SILIFE_STREAM_MIRROR_EN
          mirror_d    = cfg_mirror;
`endif
          if (init_pending_q || (cfg_intensity != init_int_q)) begin
            state_d    = S_INIT_LOAD;
            init_idx_d = '0;
            init_int_d = cfg_intensity;
          end else begin
            state_d = S_ROW_LOAD;
          end
        end
      end
      S_INIT_LOAD: begin
        load_go   = 1'b1;
        load_word = {CHAIN{init_cmd(init_idx_q, intensity_q)}};
        state_d   = S_INIT_SHIFT;
      end
      S_ROW_LOAD: begin
        // First cycle lets the grid respond to row_sel; the second captures row_data.
        if (!load_ph_q) begin
          load_ph_d = 1'b1;
        end else begin
          load_ph_d = 1'b0;
          load_go   = 1'b1;
          load_word = row_frame(row_q, row_word);
          state_d   = S_ROW_SHIFT;
        end
      end
      S_INIT_SHIFT, S_ROW_SHIFT: begin
        if (gap_q) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == {div_q, 1'b1}) xfer_end = 1'b1;
        end else if (tick_q != {1'b0, div_q}) begin
          tick_d = tick_q + 1'b1;
        end else begin
          tick_d = '0;
          sck_d  = ~sck_q;
          if (sck_q) begin
            bit_d = bit_q + 1'b1;
            if (bit_q == BCW'(NBITS - 1)) begin
              cs_d   = 1'b1;
              mosi_d = 1'b0;
              gap_d  = 1'b1;
            end else begin
              shift_d = shift_q << 1;
              mosi_d  = shift_q[NBITS-2];
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load_go) begin
      shift_d = load_word;
      mosi_d  = load_word[NBITS-1];
      cs_d    = 1'b0;
      sck_d   = 1'b0;
      tick_d  = '0;
      bit_d   = '0;
      gap_d   = 1'b0;
    end

    if (xfer_end) begin
      gap_d  = 1'b0;
      tick_d = '0;
      if (state_q == S_INIT_SHIFT) begin
        if (init_idx_q == 3'd4) begin
          init_pending_d = 1'b0;
          row_d          = '0;
          load_ph_d      = 1'b0;
          state_d        = S_ROW_LOAD;
        end else begin
          init_idx_d = init_idx_q + 3'd1;
          state_d    = S_INIT_LOAD;
        end
      end else if (row_q == 3'd7) begin
        row_d   = '0;
        state_d = S_DONE;
      end else begin
        row_d     = row_q + 3'd1;
        load_ph_d = 1'b0;
        state_d   = S_ROW_LOAD;
      end
    end

    // A changed intensity always forces a fresh init on the next frame.
    if (cfg_intensity != init_int_q) init_pending_d = 1'b1;
  end

  assign row_sel    = row_q;
  assign spi_cs     = cs_q;
  assign spi_sck    = sck_q;
  assign spi_mosi   = mosi_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_silife_max7219_stream.sv
// Bench for silife_max7219_stream (CHAIN=2): decodes the SPI pins into words and compares them
// with a transaction list built from the MAX7219 command rules; also measures SCK/CS timing.
`timescale 1ns/1ps
module tb_silife_max7219_stream;
  localparam int CHAIN = 2;
  localparam int DIV_W = 8;
  localparam int W     = 8 * CHAIN;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_start;
  logic [DIV_W-1:0] cfg_div;
  logic [3:0]       cfg_intensity;
`ifdef SILIFE_STREAM_MIRROR_EN
  logic             cfg_mirror;
`endif
  logic [2:0]       row_sel;
  logic [W-1:0]     row_data = '0;
  logic             spi_cs, spi_sck, spi_mosi, busy, frame_done;

  logic [W-1:0]     mem [8];
  int               tests = 0;
  int               fails = 0;

  always #5 clk = ~clk;

  silife_max7219_stream #(.CHAIN(CHAIN), .DIV_W(DIV_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_start     (cfg_start),
    .cfg_div       (cfg_div),
    .cfg_intensity (cfg_intensity),
`ifdef SILIFE_STREAM_MIRROR_EN
    .cfg_mirror    (cfg_mirror),
`endif
    .row_sel       (row_sel),
    .row_data      (row_data),
    .spi_cs        (spi_cs),
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  // Grid read port: registered, so data follows row_sel by one clock.
  always @(posedge clk) row_data <= mem[row_sel];

  // SPI receiver: shift MOSI on each SCK rise while CS is low; log a word when CS rises.
  logic [63:0] cur_word = '0;
  int          cur_bits = 0;
  logic [63:0] got_q [$];
  int          got_bits [$];
  always @(negedge spi_cs) begin cur_word = '0; cur_bits = 0; end
  always @(posedge spi_sck) if (spi_cs === 1'b0) begin
    cur_word = {cur_word[62:0], spi_mosi};
    cur_bits++;
  end
  always @(posedge spi_cs) if (reset === 1'b0) begin
    got_q.push_back(cur_word);
    got_bits.push_back(cur_bits);
  end

  // Cycle-level timing monitor sampled on the falling clock edge.
  int cs_lo_run = 0, cs_hi_run = 0, hi_run = 0, lo_run = 0, sck_bad = 0;
  int cs_lo_min, cs_lo_max, gap_min, hi_min, hi_max, lo_min, lo_max;
  logic prev_cs = 1'b1;
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      cs_lo_run = 0; cs_hi_run = 0; hi_run = 0; lo_run = 0; prev_cs = 1'b1;
    end else begin
      if (spi_cs === 1'b0) begin
        if (cs_hi_run > 0 && cs_hi_run < gap_min) gap_min = cs_hi_run;
        cs_hi_run = 0;
        cs_lo_run++;
        if (spi_sck === 1'b1) begin
          if (lo_run > 0) begin lo_min = (lo_run < lo_min) ? lo_run : lo_min; lo_max = (lo_run > lo_max) ? lo_run : lo_max; end
          lo_run = 0; hi_run++;
        end else begin
          if (hi_run > 0) begin hi_min = (hi_run < hi_min) ? hi_run : hi_min; hi_max = (hi_run > hi_max) ? hi_run : hi_max; end
          hi_run = 0; lo_run++;
        end
      end else begin
        if (cs_lo_run > 0) begin
          cs_lo_min = (cs_lo_run < cs_lo_min) ? cs_lo_run : cs_lo_min;
          cs_lo_max = (cs_lo_run > cs_lo_max) ? cs_lo_run : cs_lo_max;
        end
        if (hi_run > 0) begin hi_min = (hi_run < hi_min) ? hi_run : hi_min; hi_max = (hi_run > hi_max) ? hi_run : hi_max; end
        if (prev_cs === 1'b0 && spi_sck !== 1'b0) sck_bad++;
        cs_lo_run = 0; hi_run = 0; lo_run = 0;
        cs_hi_run++;
      end
      prev_cs = spi_cs;
    end
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model state: what the display chain has been told so far.
  bit         model_pending = 1'b1;
  logic [3:0] model_int     = 4'h0;

  function automatic logic [W-1:0] mirror_row(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) if (v[i]) r = r | (W'(1) << (W - 1 - i));
    return r;
  endfunction

  task automatic flush_monitors();
    got_q.delete();
    got_bits.delete();
    sck_bad   = 0;
    cs_lo_min = 1 << 30; cs_lo_max = 0; gap_min = 1 << 30;
    hi_min    = 1 << 30; hi_max    = 0; lo_min  = 1 << 30; lo_max = 0;
  endtask

  task automatic run_frame(input int div, input logic [3:0] inten, input bit mirror, input bit poke);
    logic [63:0] exp_q [$];
    logic [15:0] cmds [5];
    logic [63:0] fr;
    logic [W-1:0] v;
    int          byte_v;
    bit          do_init;
    bit          done_seen;

    do_init = model_pending || (inten != model_int);
    if (do_init) begin
      cmds[0] = 16'h0C01; cmds[1] = 16'h0900; cmds[2] = 16'h0B07;
      cmds[3] = 16'h0A00 + {12'h000, inten};   cmds[4] = 16'h0F00;
      for (int c = 0; c < 5; c++) begin
        fr = '0;
        for (int d = 0; d < CHAIN; d++) fr = fr | (64'(cmds[c]) << (16 * d));
        exp_q.push_back(fr);
      end
    end
    for (int r = 0; r < 8; r++) begin
      v  = mirror ? mirror_row(mem[r]) : mem[r];
      fr = '0;
      for (int d = 0; d < CHAIN; d++) begin
        byte_v = (int'(v) >> (8 * d)) & 255;
        fr = fr | (64'((r + 1) * 256 + byte_v) << (16 * d));
      end
      exp_q.push_back(fr);
    end

    flush_monitors();
    cfg_div       = DIV_W'(div);
    cfg_intensity = inten;
`ifdef SILIFE_STREAM_MIRROR_EN
    cfg_mirror    = mirror;
`endif
    @(negedge clk);
    cfg_start = 1'b1;
    #1 check("busy_before_edge", 64'(busy), 64'd0);
    @(negedge clk);
    cfg_start = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
    if (poke) begin
      repeat (40) @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
    end

    done_seen = 1'b0;
    for (int c = 0; c < 40000 && !done_seen; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) done_seen = 1'b1;
    end
    check("frame_done_seen", 64'(done_seen), 64'd1);
    check("busy_low_at_done", 64'(busy), 64'd0);
    check("row_sel_at_done", 64'(row_sel), 64'd0);
    @(negedge clk);
    check("frame_done_single", 64'(frame_done), 64'd0);
    repeat (30) @(negedge clk);
    check("idle_after_frame", 64'(busy), 64'd0);

    check("xfer_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check($sformatf("word[%0d]", i), got_q[i], exp_q[i]);
        check($sformatf("bits[%0d]", i), 64'(got_bits[i]), 64'(16 * CHAIN));
      end
    end
    check("sck_low_at_cs_rise", 64'(sck_bad), 64'd0);

    if (do_init) begin
      model_pending = 1'b0;
      model_int     = inten;
    end
  endtask

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_div = '0; cfg_intensity = 4'h0;
`ifdef SILIFE_STREAM_MIRROR_EN
    cfg_mirror = 1'b0;
`endif
    for (int i = 0; i < 8; i++) mem[i] = '0;
    flush_monitors();

    // Reset values are visible before the first clock edge.
    #1;
    check("rst_cs", 64'(spi_cs), 64'd1);
    check("rst_sck", 64'(spi_sck), 64'd0);
    check("rst_mosi", 64'(spi_mosi), 64'd0);
    check("rst_row_sel", 64'(row_sel), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Frame A: fastest SCK, init pending from reset, directed rows 0 and 7.
    for (int i = 0; i < 8; i++) mem[i] = W'($urandom);
    mem[0] = 16'hA55A;
    mem[7] = 16'h00FF;
    run_frame(0, 4'h5, 1'b0, 1'b0);
    if (got_q.size() >= 13) begin
      check("row0_word", got_q[5], 64'h01A5015A);
      check("row7_word", got_q[12], 64'h080008FF);
    end
    check("cs_low_min_div0", 64'(cs_lo_min), 64'd64);
    check("cs_low_max_div0", 64'(cs_lo_max), 64'd64);

    // Frame B: same intensity, so rows only.
    for (int i = 0; i < 8; i++) mem[i] = W'($urandom);
    run_frame(0, 4'h5, 1'b0, 1'b0);
    check("no_init_count", 64'(got_q.size()), 64'd8);

    // Frame C: intensity change re-runs init.
    for (int i = 0; i < 8; i++) mem[i] = W'($urandom);
    run_frame(1, 4'h9, 1'b0, 1'b0);
    check("reinit_count", 64'(got_q.size()), 64'd13);

    // Frame D: div=3 timing, plus a start pulse while busy.
    for (int i = 0; i < 8; i++) mem[i] = W'($urandom);
    run_frame(3, 4'h9, 1'b0, 1'b1);
    check("sck_high_min", 64'(hi_min), 64'd4);
    check("sck_high_max", 64'(hi_max), 64'd4);
    check("sck_low_min", 64'(lo_min), 64'd4);
    check("sck_low_max", 64'(lo_max), 64'd4);
    check("cs_low_min_div3", 64'(cs_lo_min), 64'd256);
    check("cs_low_max_div3", 64'(cs_lo_max), 64'd256);
    check("latch_gap_min", 64'(gap_min >= 8), 64'd1);

    // Asynchronous reset in the middle of a row shift.
    cfg_div = 8'd1;
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (60) @(negedge clk);
    check("pre_reset_cs_low", 64'(spi_cs), 64'd0);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_cs", 64'(spi_cs), 64'd1);
    check("midrst_sck", 64'(spi_sck), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_row_sel", 64'(row_sel), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_pending = 1'b1;

    // Frame E: reset re-armed init even though intensity is unchanged.
    for (int i = 0; i < 8; i++) mem[i] = W'($urandom);
    run_frame(0, 4'h9, 1'b0, 1'b0);
    check("post_reset_init_count", 64'(got_q.size()), 64'd13);

`ifdef SILIFE_STREAM_MIRROR_EN
    for (int i = 0; i < 8; i++) mem[i] = W'($urandom);
    mem[0] = 16'h0001;
    run_frame(0, 4'h9, 1'b1, 1'b0);
    if (got_q.size() >= 1) check("mirror_row0", got_q[0], 64'h01800100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
